// File: rtl/vga_pkg.sv
// Shared VGA pipeline types: active area, widths and the timing bundle
// carried between draw stages.
package vga_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 1024;
  localparam int COUNT_W  = 11;
  localparam int RGB_W    = 12;

  localparam logic [RGB_W-1:0] KEY_DEFAULT = 12'hF0F;

  typedef struct packed {
    logic [COUNT_W-1:0] vcount;
    logic               vsync;
    logic               vblnk;
    logic [COUNT_W-1:0] hcount;
    logic               hsync;
    logic               hblnk;
  } vga_tim_t;

  localparam int TIM_W = $bits(vga_tim_t);

endpackage

// File: rtl/vga_delay.sv
// Width/depth parameterised shift register used to keep the timing
// bundle aligned with pixel data across draw stages.
module vga_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             pclk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/draw_player.sv
// Player sprite overlay stage with colour-key transparency, 2-cycle latency.
// Optional DRAW_PLAYER_MIRROR_EN adds a frame-latched horizontal flip.
module draw_player
  import vga_pkg::*;
#(
  parameter int               SPR_W   = 48,
  parameter int               SPR_H   = 64,
  parameter int               ADDR_W  = 12,
  parameter logic [RGB_W-1:0] KEY_RGB = KEY_DEFAULT
) (
  input  logic               pclk_in,
  input  logic               rst_in,
  input  logic [COUNT_W-1:0] vcount_in,
  input  logic               vsync_in,
  input  logic               vblnk_in,
  input  logic [COUNT_W-1:0] hcount_in,
  input  logic               hsync_in,
  input  logic               hblnk_in,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic [COUNT_W-1:0] xpos,
  input  logic [COUNT_W-1:0] ypos,
  input  logic [RGB_W-1:0]   rgb_pixel,
`ifdef DRAW_PLAYER_MIRROR_EN
  input  logic               mirror,
`endif
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic [COUNT_W-1:0] vcount_out,
  output logic               vsync_out,
  output logic               vblnk_out,
  output logic [COUNT_W-1:0] hcount_out,
  output logic               hsync_out,
  output logic               hblnk_out,
  output logic [RGB_W-1:0]   rgb_out
);

  localparam int S1_W = TIM_W + RGB_W + 1;

  vga_tim_t           tim_in;
  vga_tim_t           tim_d;
  vga_tim_t           tim_o;
  logic [RGB_W-1:0]   rgb_d;
  logic               hit_d;
  logic               hit_c;
  logic               vblnk_q;
  logic [COUNT_W-1:0] xpos_q;
  logic [COUNT_W-1:0] ypos_q;
  logic [11:0]        h12, v12, x12, y12;
  logic [11:0]        x_end, y_end;
  logic [11:0]        rel_x, rel_y, col;
  logic [ADDR_W-1:0]  addr_c;

  always_comb begin
    tim_in        = '0;
    tim_in.vcount = vcount_in;
    tim_in.vsync  = vsync_in;
    tim_in.vblnk  = vblnk_in;
    tim_in.hcount = hcount_in;
    tim_in.hsync  = hsync_in;
    tim_in.hblnk  = hblnk_in;
  end

  // Position only moves on the vblank rise so a frame never tears
  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in) begin
      vblnk_q <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
    end else begin
      vblnk_q <= vblnk_in;
      if (vblnk_in && !vblnk_q) begin
        xpos_q <= xpos;
        ypos_q <= ypos;
      end
    end
  end

`ifdef DRAW_PLAYER_MIRROR_EN
  logic mirror_q;

  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in)
      mirror_q <= 1'b0;
    else if (vblnk_in && !vblnk_q)
      mirror_q <= mirror;
  end

  assign col = mirror_q ? (12'(SPR_W - 1) - rel_x) : rel_x;
`else
  assign col = rel_x;
`endif

  assign h12   = {1'b0, hcount_in};
  assign v12   = {1'b0, vcount_in};
  assign x12   = {1'b0, xpos_q};
  assign y12   = {1'b0, ypos_q};
  assign x_end = x12 + 12'(SPR_W);
  assign y_end = y12 + 12'(SPR_H);
  assign rel_x = h12 - x12;
  assign rel_y = v12 - y12;

  assign hit_c = !vblnk_in && !hblnk_in &&
                 (h12 >= x12) && (h12 < x_end) &&
                 (v12 >= y12) && (v12 < y_end);

  assign addr_c = ADDR_W'(24'(rel_y) * 24'(SPR_W) + 24'(col));

  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in)
      pixel_addr <= '0;
    else if (hit_c)
      pixel_addr <= addr_c;
  end

  vga_delay #(
    .WIDTH (S1_W),
    .DEPTH (1)
  ) u_stage1 (
    .pclk_in (pclk_in),
    .rst_in  (rst_in),
    .din     ({tim_in, rgb_in, hit_c}),
    .dout    ({tim_d, rgb_d, hit_d})
  );

  vga_delay #(
    .WIDTH (TIM_W),
    .DEPTH (1)
  ) u_stage2 (
    .pclk_in (pclk_in),
    .rst_in  (rst_in),
    .din     (tim_d),
    .dout    (tim_o)
  );

  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in)
      rgb_out <= '0;
    else if (hit_d && (rgb_pixel != KEY_RGB))
      rgb_out <= rgb_pixel;
    else
      rgb_out <= rgb_d;
  end

  assign vcount_out = tim_o.vcount;
  assign vsync_out  = tim_o.vsync;
  assign vblnk_out  = tim_o.vblnk;
  assign hcount_out = tim_o.hcount;
  assign hsync_out  = tim_o.hsync;
  assign hblnk_out  = tim_o.hblnk;

endmodule

// File: tb/tb_draw_player.sv
// Scoreboard bench for draw_player: random pixels, directed sprite placements,
// reference model in plain screen arithmetic.
module tb_draw_player;

  localparam int SPR_W = 48;
  localparam int SPR_H = 64;
  localparam logic [11:0] KEY = 12'hF0F;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic [10:0] vcount_in = '0, hcount_in = '0;
  logic        vsync_in = 1'b0, vblnk_in = 1'b0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] xpos = '0, ypos = '0;
  logic [11:0] rgb_pixel;
  logic        mirror = 1'b0;
  logic [11:0] pixel_addr;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_out;

  int rom_mode = 0;
  int checks   = 0;
  int errors   = 0;

  typedef struct {
    logic [25:0] tim;
    logic [11:0] rgb;
    logic [11:0] addr;
  } exp_t;

  exp_t q[$];

  int lx, ly, last_addr;
  bit lm, pvb;

  always #5 pclk = ~pclk;

  draw_player dut (
    .pclk_in    (pclk),
    .rst_in     (rst),
    .vcount_in  (vcount_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .hcount_in  (hcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .rgb_in     (rgb_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .rgb_pixel  (rgb_pixel),
`ifdef DRAW_PLAYER_MIRROR_EN
    .mirror     (mirror),
`endif
    .pixel_addr (pixel_addr),
    .vcount_out (vcount_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .hcount_out (hcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .rgb_out    (rgb_out)
  );

  function automatic logic [11:0] rom_f(input int a, input int mode);
    case (mode)
      0:       return 12'(a);
      1:       return KEY;
      default: return (a % 5 == 0) ? KEY : 12'(a * 7 + 3);
    endcase
  endfunction

  // Sprite ROM: data for the address presented is sampled on the next edge
  always_comb rgb_pixel = rom_f(int'(pixel_addr), rom_mode);

  task automatic model_reset();
    lx = 0; ly = 0; lm = 1'b0; pvb = 1'b0; last_addr = 0;
    q.delete();
  endtask

  task automatic drive(input int h, input int v);
    exp_t e;
    bit hb, vb, hs, vs, hit;
    int col;
    logic [11:0] pix, bg;
    hb = (h >= 1280);
    vb = (v >= 1024);
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    bg = 12'($urandom);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = hb; vblnk_in = vb;
    hsync_in = hs; vsync_in = vs;
    rgb_in = bg;
    hit = !vb && !hb && h >= lx && h < lx + SPR_W &&
          v >= ly && v < ly + SPR_H;
    col = lm ? (SPR_W - 1 - (h - lx)) : (h - lx);
    if (hit) last_addr = (v - ly) * SPR_W + col;
    pix = rom_f(last_addr, rom_mode);
    e.tim  = {11'(v), vs, vb, 11'(h), hs, hb};
    e.rgb  = (hit && pix != KEY) ? pix : bg;
    e.addr = 12'(last_addr);
    q.push_back(e);
    if (!pvb && vb) begin
      lx = int'(xpos); ly = int'(ypos); lm = mirror;
    end
    pvb = vb;
    @(posedge pclk); #1;
  endtask

  task automatic check_zero(input string name);
    logic [51:0] got;
    got = {vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out,
           hblnk_out, rgb_out, pixel_addr};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s got %h want 0", name, got);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_zero("reset_async");
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    check_zero("reset_hold");
    rst = 1'b1;
  endtask

  task automatic frame(input int ax0, input int ax1, input int bx0,
                       input int bx1, input int y0, input int y1,
                       input int chg_row, input int chg_x);
    for (int i = 0; i < 3; i++) drive(1300, 1030);
    for (int v = y0; v <= y1; v++) begin
      if (v == chg_row) xpos = 11'(chg_x);
      for (int h = ax0; h <= ax1; h++) drive(h, v);
      for (int h = 1280; h < 1284; h++) drive(h, v);
      for (int h = bx0; h <= bx1; h++) drive(h, v);
    end
    for (int i = 0; i < 2; i++) drive(1290, y1);
  endtask

  always @(negedge pclk) begin
    if (rst && q.size() >= 3) begin
      exp_t e;
      logic [25:0] tim;
      e = q.pop_front();
      tim = {vcount_out, vsync_out, vblnk_out, hcount_out, hsync_out,
             hblnk_out};
      checks++;
      if (tim !== e.tim) begin
        errors++;
        $display("FAIL timing got %h want %h", tim, e.tim);
      end
      checks++;
      if (rgb_out !== e.rgb) begin
        errors++;
        $display("FAIL rgb_out h=%0d v=%0d got %h want %h",
                 e.tim[12:2], e.tim[25:15], rgb_out, e.rgb);
      end
      checks++;
      if (pixel_addr !== q[0].addr) begin
        errors++;
        $display("FAIL pixel_addr h=%0d v=%0d got %0d want %0d",
                 q[0].tim[12:2], q[0].tim[25:15], pixel_addr, q[0].addr);
      end
    end
  end

  initial begin
    int x, y;
    model_reset();
    #1;
    check_zero("reset_init");
    repeat (2) @(posedge pclk);
    #1;
    rst = 1'b1;

    // Mid-line reset, then normal sprite at (100,200)
    xpos = 11'd100; ypos = 11'd200;
    for (int h = 90; h < 110; h++) drive(h, 200);
    do_reset();
    for (int h = 110; h < 130; h++) drive(h, 200);

    rom_mode = 0;
    frame(95, 152, 0, -1, 198, 266, -1, 0);

    rom_mode = 1;
    frame(95, 152, 0, -1, 198, 266, -1, 0);

    // Mid-frame move only shows after the next vblank rise
    rom_mode = 2;
    xpos = 11'd100; ypos = 11'd470;
    frame(95, 152, 395, 452, 468, 536, 500, 400);
    frame(95, 152, 395, 452, 468, 536, -1, 0);

    // Right-edge clipping, no wrap into the low columns
    rom_mode = 0;
    xpos = 11'd1260; ypos = 11'd10;
    frame(1250, 1279, 0, 30, 8, 76, -1, 0);
    frame(1250, 1279, 0, 30, 8, 76, -1, 0);

    // Off-screen position draws nothing
    xpos = 11'd1290; ypos = 11'd300;
    frame(1270, 1279, 0, 10, 298, 305, -1, 0);
    frame(1270, 1279, 0, 10, 298, 305, -1, 0);

    for (int f = 0; f < 3; f++) begin
      rom_mode = 2;
      x = $urandom_range(0, 1300);
      y = $urandom_range(0, 940);
`ifdef DRAW_PLAYER_MIRROR_EN
      mirror = 1'($urandom_range(0, 1));
`endif
      xpos = 11'(x); ypos = 11'(y);
      frame((x > 3) ? x - 3 : 0, (x + 50 > 1279) ? 1279 : x + 50,
            0, 20, (y > 2) ? y - 2 : 0, y + SPR_H + 1,
            y + 20, $urandom_range(0, 1279));
      frame((x > 3) ? x - 3 : 0, (x + 50 > 1279) ? 1279 : x + 50,
            0, 20, (y > 2) ? y - 2 : 0, y + SPR_H + 1, -1, 0);
    end

    for (int i = 0; i < 4; i++) drive(1300, 1030);
    @(negedge pclk);
    #1;
    checks++;
    if (q.size() > 2) begin
      errors++;
      $display("FAIL drain got %0d want <=2", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
